// File: rtl/ro_buffer.sv
// Reorder buffer: hands out ROB ids, captures results from the rss/lsb buses,
// answers operand-readiness queries and retires in order with mispredict flush.
module ro_buffer #(
   parameter int unsigned ROB_SIZE = 16,
   parameter int unsigned ID_W     = 5,
   parameter int unsigned XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            valid_from_issuer,
   input  logic [1:0]      kind_from_issuer,
   input  logic [4:0]      rd_from_issuer,
   input  logic [XLEN-1:0] pred_pc_from_issuer,
   output logic [ID_W-1:0] next_id_to_issuer,
   output logic            is_ro_buffer_full,
   input  logic [ID_W-1:0] query_j_id,
   input  logic [ID_W-1:0] query_k_id,
   output logic            query_j_ready,
   output logic            query_k_ready,
   output logic [XLEN-1:0] query_j_value,
   output logic [XLEN-1:0] query_k_value,
   input  logic [ID_W-1:0] dest_from_rss_bus,
   input  logic [XLEN-1:0] value_from_rss_bus,
   input  logic [XLEN-1:0] next_pc_from_rss_bus,
   input  logic [ID_W-1:0] dest_from_lsb_bus,
   input  logic [XLEN-1:0] value_from_lsb_bus,
   output logic [ID_W-1:0] commit_id_to_regfile,
   output logic [4:0]      commit_rd_to_regfile,
   output logic [XLEN-1:0] commit_value_to_regfile,
   output logic [ID_W-1:0] commit_store_id_to_lsb,
   output logic            reset_to_rob_bus,
   output logic [XLEN-1:0] target_pc_to_fetcher
);
   localparam logic [ID_W-1:0] LAST_ID     = ID_W'(ROB_SIZE);
   localparam logic [1:0]      KIND_BRANCH = 2'd1;
   localparam logic [1:0]      KIND_STORE  = 2'd2;

   logic            r_busy  [1:ROB_SIZE];
   logic            r_ready [1:ROB_SIZE];
   logic [1:0]      r_kind  [1:ROB_SIZE];
   logic [4:0]      r_rd    [1:ROB_SIZE];
   logic [XLEN-1:0] r_pred  [1:ROB_SIZE];
   logic [XLEN-1:0] r_value [1:ROB_SIZE];
   logic [XLEN-1:0] r_npc   [1:ROB_SIZE];
   logic [ID_W-1:0] r_head;
   logic [ID_W-1:0] r_tail;
   logic [ID_W-1:0] r_count;

   logic [ID_W-1:0] r_commit_id;
   logic [4:0]      r_commit_rd;
   logic [XLEN-1:0] r_commit_value;
   logic [ID_W-1:0] r_commit_store_id;
   logic            r_flush;
   logic [XLEN-1:0] r_target_pc;

   logic            w_full;
   logic            w_issue;
   logic            w_commit;
   logic            w_mispredict;
   logic [ID_W-1:0] w_q_id    [2];
   logic            w_q_ready [2];
   logic [XLEN-1:0] w_q_value [2];

   // Slots are numbered 1..ROB_SIZE; id 0 is reserved for "none".
   function automatic logic [ID_W-1:0] f_inc(input logic [ID_W-1:0] p);
      return (p == LAST_ID) ? ID_W'(1) : p + ID_W'(1);
   endfunction

   assign w_full       = r_count >= ID_W'(ROB_SIZE - 1);
   assign w_issue      = valid_from_issuer && !w_full && !r_flush;
   assign w_commit     = r_busy[r_head] && r_ready[r_head];
   assign w_mispredict = w_commit && (r_kind[r_head] == KIND_BRANCH) &&
                         (r_npc[r_head] != r_pred[r_head]);

   assign w_q_id[0] = query_j_id;
   assign w_q_id[1] = query_k_id;

   // Bus bypass lets an operand resolved this cycle be consumed without a bubble.
   always_comb begin
      for (int q = 0; q < 2; q++) begin
         w_q_ready[q] = 1'b0;
         w_q_value[q] = '0;
         if (w_q_id[q] == '0) begin
            w_q_ready[q] = 1'b1;
         end else if (dest_from_rss_bus == w_q_id[q]) begin
            w_q_ready[q] = 1'b1;
            w_q_value[q] = value_from_rss_bus;
         end else if (dest_from_lsb_bus == w_q_id[q]) begin
            w_q_ready[q] = 1'b1;
            w_q_value[q] = value_from_lsb_bus;
         end else if (w_q_id[q] <= LAST_ID && r_ready[w_q_id[q]]) begin
            w_q_ready[q] = 1'b1;
            w_q_value[q] = r_value[w_q_id[q]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 1; i <= ROB_SIZE; i++) begin
            r_busy[i]  <= 1'b0;
            r_ready[i] <= 1'b0;
            r_kind[i]  <= '0;
            r_rd[i]    <= '0;
            r_pred[i]  <= '0;
            r_value[i] <= '0;
            r_npc[i]   <= '0;
         end
         r_head            <= ID_W'(1);
         r_tail            <= ID_W'(1);
         r_count           <= '0;
         r_commit_id       <= '0;
         r_commit_rd       <= '0;
         r_commit_value    <= '0;
         r_commit_store_id <= '0;
         r_flush           <= 1'b0;
         r_target_pc       <= '0;
      end else if (!rdy) begin
         r_commit_id       <= '0;
         r_commit_rd       <= '0;
         r_commit_value    <= '0;
         r_commit_store_id <= '0;
         r_flush           <= 1'b0;
         r_target_pc       <= '0;
      end else begin
         r_commit_id       <= '0;
         r_commit_rd       <= '0;
         r_commit_value    <= '0;
         r_commit_store_id <= '0;
         r_flush           <= 1'b0;
         r_target_pc       <= '0;

         if (w_commit) begin
            r_commit_id <= r_head;
            if (r_kind[r_head] == KIND_STORE) begin
               r_commit_store_id <= r_head;
            end else begin
               r_commit_rd    <= r_rd[r_head];
               r_commit_value <= r_value[r_head];
            end
         end

         if (w_mispredict) begin
            for (int unsigned i = 1; i <= ROB_SIZE; i++) begin
               r_busy[i]  <= 1'b0;
               r_ready[i] <= 1'b0;
            end
            r_head      <= ID_W'(1);
            r_tail      <= ID_W'(1);
            r_count     <= '0;
            r_flush     <= 1'b1;
            r_target_pc <= r_npc[r_head];
         end else begin
            if (!r_flush) begin
               for (int unsigned i = 1; i <= ROB_SIZE; i++) begin
                  if (r_busy[i] && dest_from_rss_bus == ID_W'(i)) begin
                     r_value[i] <= value_from_rss_bus;
                     r_npc[i]   <= next_pc_from_rss_bus;
                     r_ready[i] <= 1'b1;
                  end
                  if (r_busy[i] && dest_from_lsb_bus == ID_W'(i)) begin
                     r_value[i] <= value_from_lsb_bus;
                     r_ready[i] <= 1'b1;
                  end
               end
            end
            if (w_commit) begin
               r_busy[r_head]  <= 1'b0;
               r_ready[r_head] <= 1'b0;
               r_head          <= f_inc(r_head);
            end
            if (w_issue) begin
               r_busy[r_tail]  <= 1'b1;
               r_ready[r_tail] <= 1'b0;
               r_kind[r_tail]  <= kind_from_issuer;
               r_rd[r_tail]    <= rd_from_issuer;
               r_pred[r_tail]  <= pred_pc_from_issuer;
               r_tail          <= f_inc(r_tail);
            end
            r_count <= r_count + ID_W'(w_issue) - ID_W'(w_commit);
         end
      end
   end

   assign next_id_to_issuer       = r_tail;
   assign is_ro_buffer_full       = w_full;
   assign query_j_ready           = w_q_ready[0];
   assign query_k_ready           = w_q_ready[1];
   assign query_j_value           = w_q_value[0];
   assign query_k_value           = w_q_value[1];
   assign commit_id_to_regfile    = r_commit_id;
   assign commit_rd_to_regfile    = r_commit_rd;
   assign commit_value_to_regfile = r_commit_value;
   assign commit_store_id_to_lsb  = r_commit_store_id;
   assign reset_to_rob_bus        = r_flush;
   assign target_pc_to_fetcher    = r_target_pc;

endmodule

// File: doc/ro_buffer.md
Name: ro_buffer

Overview:
- Reorder buffer that sits directly downstream of the ALU reservation station and the load/store buffer.
- Allocates the ROB id that tags every issued instruction and captures results broadcast on the rss and lsb buses.
- Answers operand-readiness queries from the issuer.
- Retires instructions strictly in order: register writes, store release, and branch-mispredict flush via the rob reset bus.

Parameters:
ROB_SIZE, 16, number of entries; ids 1..ROB_SIZE, id 0 means "none"
ID_W, 5, ROB id width
XLEN, 32, data/pc width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
rdy  input  1  global enable; when 0 all state holds
valid_from_issuer  input  1  issue request this cycle
kind_from_issuer  input  2  0=alu/load (writes rd), 1=branch/jump, 2=store
rd_from_issuer  input  5  destination register, 0 = none
pred_pc_from_issuer  input  XLEN  predicted next pc (branch/jump only)
next_id_to_issuer  output  ID_W  id the next issued instruction receives (combinational = tail)
is_ro_buffer_full  output  1  count >= ROB_SIZE-1 (pre-full)
query_j_id, query_k_id  input  ID_W  operand tags to look up
query_j_ready, query_k_ready  output  1  tag's value is available (combinational)
query_j_value, query_k_value  output  XLEN  that value
dest_from_rss_bus  input  ID_W  ALU result tag, 0 = idle
value_from_rss_bus  input  XLEN  ALU result
next_pc_from_rss_bus  input  XLEN  resolved next pc
dest_from_lsb_bus  input  ID_W  load result / store-address-ready tag, 0 = idle
value_from_lsb_bus  input  XLEN  load value
commit_id_to_regfile  output  ID_W  retiring id, 0 = none (pulse)
commit_rd_to_regfile  output  5  retiring rd
commit_value_to_regfile  output  XLEN  retiring value
commit_store_id_to_lsb  output  ID_W  store id released to memory, 0 = none (pulse)
reset_to_rob_bus  output  1  one-cycle flush pulse to all stages
target_pc_to_fetcher  output  XLEN  redirect pc, valid with reset_to_rob_bus

Behaviour:
- **Reset (rst=0, async):**
  - head=tail=1, count=0, all ready/busy bits 0.
  - All outputs 0, except next_id_to_issuer=1.
- **Queue:**
  - Circular over slots 1..ROB_SIZE; increment wraps ROB_SIZE→1, never to 0.
  - count updates as +issue −commit in the same edge.
- **Issue:**
  - Accepted when valid_from_issuer && !is_ro_buffer_full && !reset_to_rob_bus.
  - Stores kind, rd, pred_pc into the tail slot; sets busy=1, ready=0; advances tail.
  - Issue while full is dropped; the issuer must not do it.
- **Writeback:**
  - Any busy entry matching a nonzero dest_from_rss_bus gets value, next_pc, ready=1.
  - Any busy entry matching a nonzero dest_from_lsb_bus gets value, ready=1.
  - Both buses may fire in the same cycle on different ids.
- **Query (combinational):**
  - ready=1 if id==0, or the entry is ready, or id matches rss/lsb bus this cycle (bypass; value from the bus, rss has priority).
  - Otherwise ready=0, value=0.
- **Commit (at most one per cycle):**
  - Condition: head busy && ready (registered state only; an entry written back this cycle commits no earlier than next cycle).
  - Outputs registered; each is a 1-cycle pulse:
    - kind 0: commit_id = head, rd, value.
    - kind 1: commit_id/rd/value as kind 0, rd may be 0.
    - kind 2: commit_store_id = head; commit_id = head, rd=0.
  - After commit: head advances; busy cleared.
- **Mispredict:**
  - Trigger: committing kind 1 with stored next_pc != pred_pc.
  - Same edge:
    - reset_to_rob_bus<=1, target_pc<=next_pc.
    - Entire queue cleared (head=tail=1, count=0).
  - The following cycle:
    - reset_to_rob_bus returns to 0.
    - Issue and bus writebacks are ignored while reset_to_rob_bus=1.
  - The mispredicted instruction itself does commit (its rd is written).
- **rdy=0:** no state change; pulse outputs cleared to 0 at that edge.
- **Async reset mid-flush:** reset wins immediately.

Test Plan:
- Reset, issue 3 kind-0 instrs (rd=1,2,3) → ids 1,2,3; rss bus writes id2=0x22 then id1=0x11; id3 via lsb=0x33 → commits in order 1,2,3 on 3 consecutive cycles, values 0x11,0x22,0x33.
- Issue 15 entries without writeback → is_ro_buffer_full=1 at count=15; 16th valid ignored; commit one → full drops, next_id=16, then wraps to 1.
- query_j_id=4 while dest_from_rss_bus=4, value=0xABCD → query_j_ready=1, value=0xABCD same cycle; query id 0 → ready=1.
- Branch id1 pred_pc=0x104, rss next_pc=0x200; id2,id3 queued → on id1 commit, reset_to_rob_bus pulses 1 cycle, target_pc=0x200, next_id back to 1, id2/id3 never commit.
- Store id1 marked ready by lsb bus → commit_store_id_to_lsb=1 for one cycle, commit_rd=0.
- Hold rdy=0 for 5 cycles with ready head → no commit, outputs 0; rdy=1 → commit next edge. Drop rst mid-stream → outputs 0 immediately.
